// File: rtl/mem_lsu.sv
// mem_lsu: RV32I memory stage. It splits loads and stores into little-endian byte beats on a shared byte-wide RAM port.
// Optional build macro MEM_LSU_IO_SERIAL_EN serializes beats that address the I/O window (address bits [17:16] == 2'b11).
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_i,
    input  logic [31:0]       wdata_i,
    input  logic              wreg_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        ls_type_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [6:0]        stall,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_dout_o,
    input  logic              mem_gnt_i,
    input  logic [7:0]        mem_din_i,
    output logic              stallreq_o,
    output logic [4:0]        mem_rd,
    output logic [31:0]       mem_wdata,
    output logic              mem_wreg
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACCESS    = 2'b01,
        WAIT_LAST = 2'b10,
        DONE      = 2'b11
    } state_t;

    state_t            state_r;
    logic [1:0]        beat_r;
    logic [1:0]        last_beat_r;
    logic [1:0]        pend_idx_r;
    logic              pend_r;
    logic              gap_r;
    logic              is_load_r;
    logic [2:0]        type_r;
    logic [31:0]       result_r;
    logic [ADDR_W-1:0] beat_addr_s;
    logic              io_s;
    logic              req_s;
    logic              unused_s;

    // Only the MEM-stage bit of the stall vector matters here.
    assign unused_s = ^{stall[6:4], stall[2:0]};

    function automatic logic [1:0] last_beat_f(input logic [2:0] t);
        logic [1:0] v;
        case (t)
            3'b000, 3'b100: v = 2'd0;
            3'b001, 3'b101: v = 2'd1;
            default:        v = 2'd3;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] extend_f(input logic [2:0] t, input logic [31:0] r);
        logic [31:0] v;
        case (t)
            3'b000:  v = {{24{r[7]}}, r[7:0]};
            3'b100:  v = {24'd0, r[7:0]};
            3'b001:  v = {{16{r[15]}}, r[15:0]};
            3'b101:  v = {16'd0, r[15:0]};
            default: v = r;
        endcase
        return v;
    endfunction

    // Current beat address, I/O window decode and request qualifier
    always_comb begin
        beat_addr_s = mem_addr_i + ADDR_W'(beat_r);
`ifdef MEM_LSU_IO_SERIAL_EN
        io_s = (beat_addr_s[17:16] == 2'b11);
`else
        io_s = 1'b0;
`endif
        req_s = (state_r == ACCESS) && !gap_r;
    end

    // Access sequencer: beat counting, read-byte capture and state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            beat_r      <= 2'd0;
            last_beat_r <= 2'd0;
            pend_idx_r  <= 2'd0;
            pend_r      <= 1'b0;
            gap_r       <= 1'b0;
            is_load_r   <= 1'b0;
            type_r      <= 3'b000;
            result_r    <= 32'd0;
        end else begin
            // A byte granted last cycle is on mem_din_i now, whatever state we are in.
            pend_r <= 1'b0;
            if (pend_r) begin
                result_r[{pend_idx_r, 3'b000} +: 8] <= mem_din_i;
            end
            case (state_r)
                IDLE: begin
                    beat_r <= 2'd0;
                    gap_r  <= 1'b0;
                    if (load_i || store_i) begin
                        state_r     <= ACCESS;
                        is_load_r   <= load_i;
                        type_r      <= ls_type_i;
                        last_beat_r <= last_beat_f(ls_type_i);
                        result_r    <= 32'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (gap_r) begin
                        gap_r <= 1'b0;
                    end else if (mem_gnt_i) begin
                        pend_r     <= is_load_r;
                        pend_idx_r <= beat_r;
                        if (beat_r == last_beat_r) begin
                            state_r <= is_load_r ? WAIT_LAST : DONE;
                        end else begin
                            beat_r <= beat_r + 2'd1;
                            gap_r  <= io_s;
                        end
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                WAIT_LAST: begin
                    state_r <= DONE;
                end
                DONE: begin
                    if (!stall[3]) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output decode; reset forces every output low, including the idle pass-through
    always_comb begin
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_dout_o = 8'd0;
        stallreq_o = 1'b0;
        mem_rd     = 5'd0;
        mem_wdata  = 32'd0;
        mem_wreg   = 1'b0;
        if (rst) begin
            mem_req_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_rd    = rd_i;
                    mem_wdata = wdata_i;
                    mem_wreg  = wreg_i;
                end
                ACCESS: begin
                    stallreq_o = 1'b1;
                    mem_req_o  = req_s;
                    mem_addr_o = beat_addr_s;
                    mem_we_o   = req_s && !is_load_r;
                    if (req_s && !is_load_r) begin
                        mem_dout_o = store_data_i[{beat_r, 3'b000} +: 8];
                    end else begin
                        mem_dout_o = 8'd0;
                    end
                end
                WAIT_LAST: begin
                    stallreq_o = 1'b1;
                end
                DONE: begin
                    if (is_load_r) begin
                        mem_rd    = rd_i;
                        mem_wdata = extend_f(type_r, result_r);
                        mem_wreg  = 1'b1;
                    end else begin
                        mem_wreg = 1'b0;
                    end
                end
                default: begin
                    stallreq_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized self-checking bench for mem_lsu against a byte-memory reference model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_i = 5'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        wreg_i = 1'b0;
    logic        load_i = 1'b0;
    logic        store_i = 1'b0;
    logic [2:0]  ls_type_i = 3'b000;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] store_data_i = 32'd0;
    logic [6:0]  stall = 7'd0;
    logic        mem_req_o, mem_we_o, stallreq_o, mem_wreg;
    logic [31:0] mem_addr_o, mem_wdata;
    logic [7:0]  mem_dout_o;
    logic        mem_gnt_i = 1'b0;
    logic [7:0]  mem_din_i = 8'd0;
    logic [4:0]  mem_rd;

    int checks = 0;
    int failures = 0;

    logic [7:0]  bmem [logic [31:0]];
    logic [31:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    logic [31:0] rq_addr[$];
    int          done_c, n_stall, wreg_in_stall, addr_slip, hold_err, req_len;
    logic [31:0] d_wdata, req_trace;
    logic [4:0]  d_rd;
    logic        d_wreg, post_busy;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rd_i(rd_i), .wdata_i(wdata_i), .wreg_i(wreg_i),
        .load_i(load_i), .store_i(store_i), .ls_type_i(ls_type_i), .mem_addr_i(mem_addr_i),
        .store_data_i(store_data_i), .stall(stall), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_dout_o(mem_dout_o), .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
        .stallreq_o(stallreq_o), .mem_rd(mem_rd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic int beats_of(input logic [2:0] ty);
        if (ty == 3'b010) return 4;
        if (ty == 3'b001 || ty == 3'b101) return 2;
        if (ty == 3'b000 || ty == 3'b100) return 1;
        return 4;
    endfunction

    // Reference load value: assemble little-endian bytes, then sign/zero extend by width.
    function automatic logic [31:0] exp_load(input logic [2:0] ty, input logic [31:0] a);
        logic [7:0]  b0, b1;
        logic [31:0] w;
        b0 = mem_byte(a);
        b1 = mem_byte(a + 32'd1);
        w  = {mem_byte(a + 32'd3), mem_byte(a + 32'd2), b1, b0};
        case (ty)
            3'b000:  return 32'($signed(b0));
            3'b100:  return 32'(b0);
            3'b001:  return 32'($signed({b1, b0}));
            3'b101:  return 32'({b1, b0});
            default: return w;
        endcase
    endfunction

    // Runs one access: mode 0 = grant always, 1 = grant on odd cycles, 2 = random grant.
    task automatic do_op(input logic ld, input logic st, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input int mode, input int hold);
        int grants;
        logic g, have_din;
        logic [7:0] din_next;
        wq_addr.delete(); wq_data.delete(); rq_addr.delete();
        done_c = -1; n_stall = 0; wreg_in_stall = 0; addr_slip = 0; hold_err = 0;
        req_trace = 32'd0; req_len = 0; grants = 0; have_din = 1'b0; din_next = 8'd0;
        @(negedge clk);
        load_i = ld; store_i = st; ls_type_i = ty; mem_addr_i = a; store_data_i = sd;
        rd_i = rd; wdata_i = $urandom; wreg_i = ld; stall = 7'd0; mem_gnt_i = 1'b0;
        for (int c = 1; c < 200 && done_c < 0; c++) begin
            @(negedge clk);
            mem_din_i = have_din ? din_next : 8'($urandom);
            have_din = 1'b0;
            stall = {3'($urandom), 1'b0, 3'($urandom)};
            if (!stallreq_o) begin
                done_c = c; d_wdata = mem_wdata; d_rd = mem_rd; d_wreg = mem_wreg;
                mem_gnt_i = 1'b0;
                if (hold > 0) stall[3] = 1'b1;
            end else begin
                n_stall++;
                if (mem_wreg) wreg_in_stall++;
                req_trace = {req_trace[30:0], mem_req_o};
                req_len++;
                case (mode)
                    0: g = 1'b1;
                    1: g = ((c % 2) == 1);
                    default: g = 1'($urandom_range(0, 1));
                endcase
                if (mem_req_o) begin
                    if (mem_addr_o !== 32'(a + grants)) addr_slip++;
                    if (g) begin
                        grants++;
                        if (mem_we_o) begin
                            wq_addr.push_back(mem_addr_o);
                            wq_data.push_back(mem_dout_o);
                        end else begin
                            rq_addr.push_back(mem_addr_o);
                            din_next = mem_byte(mem_addr_o);
                            have_din = 1'b1;
                        end
                    end
                end
                mem_gnt_i = g;
            end
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            if (mem_wdata !== d_wdata || mem_rd !== d_rd || mem_wreg !== d_wreg || stallreq_o || mem_req_o)
                hold_err++;
            stall = {3'($urandom), (h < hold), 3'($urandom)};
        end
        @(negedge clk);
        post_busy = mem_req_o | stallreq_o;
        load_i = 1'b0; store_i = 1'b0; wreg_i = 1'b0; stall = 7'd0; mem_gnt_i = 1'b0;
    endtask

    task automatic test_reset();
        rd_i = 5'd5; wdata_i = 32'd7; wreg_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, stallreq_o, mem_rd, mem_wdata, mem_wreg} !== 80'd0) begin
            failures++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h dout=%h stallreq=%b rd=%0d wdata=%h wreg=%b, want all 0",
                                 mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, stallreq_o, mem_rd, mem_wdata, mem_wreg);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_wdata !== 32'd7 || mem_rd !== 5'd5 || mem_wreg !== 1'b1 || stallreq_o !== 1'b0) begin
            failures++; $display("FAIL idle_passthrough: got wdata=%h rd=%0d wreg=%b stallreq=%b, want 7/5/1/0",
                                 mem_wdata, mem_rd, mem_wreg, stallreq_o);
        end
        wreg_i = 1'b0;
    endtask

    task automatic test_lw_basic();
        bmem[32'h100] = 8'h78; bmem[32'h101] = 8'h56; bmem[32'h102] = 8'h34; bmem[32'h103] = 8'h12;
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd9, 0, 0);
        checks++;
        if (d_wdata !== 32'h12345678 || d_wreg !== 1'b1 || d_rd !== 5'd9) begin
            failures++; $display("FAIL lw_result: got %h wreg=%b rd=%0d, want 12345678 wreg=1 rd=9", d_wdata, d_wreg, d_rd);
        end
        checks++;
        if (n_stall !== 5 || done_c !== 6) begin
            failures++; $display("FAIL lw_latency: got stall=%0d done=%0d, want 5 and 6", n_stall, done_c);
        end
        checks++;
        if (rq_addr.size() !== 4 || rq_addr[0] !== 32'h100 || rq_addr[3] !== 32'h103 || req_trace !== 32'h1E) begin
            failures++; $display("FAIL lw_beats: got %0d reads trace=%h, want 4 reads 100..103 trace=1e", rq_addr.size(), req_trace);
        end
        checks++;
        if (post_busy !== 1'b0) begin
            failures++; $display("FAIL lw_release: got busy=%b after DONE, want 0", post_busy);
        end
    endtask

    task automatic test_narrow_loads();
        bmem[32'h204] = 8'h80; bmem[32'h205] = 8'hFF; bmem[32'h206] = 8'h80;
        do_op(1'b1, 1'b0, 3'b000, 32'h204, 32'd0, 5'd1, 0, 0);
        checks++;
        if (d_wdata !== 32'hFFFFFF80 || done_c !== 3) begin
            failures++; $display("FAIL lb_sign: got %h done=%0d, want ffffff80 done=3", d_wdata, done_c);
        end
        do_op(1'b1, 1'b0, 3'b100, 32'h204, 32'd0, 5'd2, 0, 0);
        checks++;
        if (d_wdata !== 32'h00000080) begin
            failures++; $display("FAIL lbu_zero: got %h, want 00000080", d_wdata);
        end
        do_op(1'b1, 1'b0, 3'b101, 32'h205, 32'd0, 5'd3, 0, 0);
        checks++;
        if (d_wdata !== 32'h000080FF || rq_addr.size() !== 2) begin
            failures++; $display("FAIL lhu_misaligned: got %h reads=%0d, want 000080ff reads=2", d_wdata, rq_addr.size());
        end
    endtask

    task automatic test_store_wrap();
        do_op(1'b0, 1'b1, 3'b001, 32'hFFFFFFFF, 32'h1234ABCD, 5'd4, 0, 0);
        checks++;
        if (wq_addr.size() !== 2) begin
            failures++; $display("FAIL sh_wrap_count: got %0d writes, want 2", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 32'hFFFFFFFF || wq_data[0] !== 8'hCD || wq_addr[1] !== 32'h0 || wq_data[1] !== 8'hAB) begin
                failures++; $display("FAIL sh_wrap_bytes: got %h@%h %h@%h, want cd@ffffffff ab@00000000",
                                     wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
            end
        end
        checks++;
        if (d_wreg !== 1'b0 || d_rd !== 5'd0 || d_wdata !== 32'd0 || done_c !== 3) begin
            failures++; $display("FAIL sh_done: got wreg=%b rd=%0d wdata=%h done=%0d, want 0/0/0 done=3", d_wreg, d_rd, d_wdata, done_c);
        end
        do_op(1'b0, 1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 5'd4, 0, 0);
        checks++;
        if (done_c !== 5 || wq_data.size() !== 4 || wq_data[3] !== 8'hDE) begin
            failures++; $display("FAIL sw_latency: got done=%0d writes=%0d, want done=5 writes=4 last=de", done_c, wq_data.size());
        end
    endtask

    task automatic test_toggle_grant();
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd6, 1, 0);
        checks++;
        if (d_wdata !== 32'h12345678 || addr_slip !== 0) begin
            failures++; $display("FAIL toggle_lw: got %h slips=%0d, want 12345678 slips=0", d_wdata, addr_slip);
        end
        checks++;
        if (n_stall !== 8 || wreg_in_stall !== 0) begin
            failures++; $display("FAIL toggle_stall: got stall=%0d wreg_in_stall=%0d, want 8 and 0", n_stall, wreg_in_stall);
        end
    endtask

    task automatic test_done_hold();
        do_op(1'b1, 1'b0, 3'b001, 32'h204, 32'd0, 5'd11, 0, 3);
        checks++;
        if (hold_err !== 0 || d_wdata !== 32'hFFFFFF80 || post_busy !== 1'b0) begin
            failures++; $display("FAIL done_hold: got errs=%0d data=%h busy=%b, want 0 ffffff80 0", hold_err, d_wdata, post_busy);
        end
    endtask

    task automatic test_both_high();
        do_op(1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, 5'd12, 0, 0);
        checks++;
        if (wq_addr.size() !== 0 || d_wreg !== 1'b1 || d_wdata !== 32'h12345678) begin
            failures++; $display("FAIL both_high: got writes=%0d wreg=%b data=%h, want 0 1 12345678", wq_addr.size(), d_wreg, d_wdata);
        end
    endtask

    task automatic test_io_serial();
        logic [31:0] exp_trace;
        int          exp_len;
        bmem[32'h30000] = 8'h11; bmem[32'h30001] = 8'h22; bmem[32'h30002] = 8'h33; bmem[32'h30003] = 8'h44;
`ifdef MEM_LSU_IO_SERIAL_EN
        exp_trace = 32'hAA; exp_len = 8;
`else
        exp_trace = 32'h1E; exp_len = 5;
`endif
        do_op(1'b1, 1'b0, 3'b010, 32'h30000, 32'd0, 5'd13, 0, 0);
        checks++;
        if (req_trace !== exp_trace || req_len !== exp_len || d_wdata !== 32'h44332211) begin
            failures++; $display("FAIL io_pattern: got trace=%h len=%0d data=%h, want %h len=%0d 44332211",
                                 req_trace, req_len, d_wdata, exp_trace, exp_len);
        end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        store_i = 1'b1; load_i = 1'b0; ls_type_i = 3'b010; mem_addr_i = 32'h400;
        store_data_i = 32'hCAFEF00D; rd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h400; mem_gnt_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h401 || mem_dout_o !== 8'hF0) begin
            failures++; $display("FAIL sw_beat2: got req=%b addr=%h dout=%h, want 1 401 f0", mem_req_o, mem_addr_o, mem_dout_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, stallreq_o, mem_rd, mem_wdata, mem_wreg} !== 80'd0) begin
            failures++; $display("FAIL reset_mid_sw: got req=%b we=%b addr=%h dout=%h stallreq=%b, want all 0",
                                 mem_req_o, mem_we_o, mem_addr_o, mem_dout_o, stallreq_o);
        end
        @(negedge clk);
        rst = 1'b0; store_i = 1'b0; load_i = 1'b0; wdata_i = 32'd7; rd_i = 5'd5; wreg_i = 1'b1;
        #1;
        checks++;
        if (mem_wdata !== 32'd7 || mem_rd !== 5'd5 || mem_wreg !== 1'b1 || stallreq_o !== 1'b0 || mem_req_o !== 1'b0) begin
            failures++; $display("FAIL add_after_reset: got wdata=%h rd=%0d wreg=%b stallreq=%b req=%b, want 7/5/1/0/0",
                                 mem_wdata, mem_rd, mem_wreg, stallreq_o, mem_req_o);
        end
        @(negedge clk);
        checks++;
        if (stallreq_o !== 1'b0 || mem_req_o !== 1'b0 || mem_wdata !== 32'd7) begin
            failures++; $display("FAIL add_no_stall: got stallreq=%b req=%b wdata=%h, want 0 0 7", stallreq_o, mem_req_o, mem_wdata);
        end
        wreg_i = 1'b0; mem_gnt_i = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  types [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  ty;
        logic [31:0] a, sd;
        logic [4:0]  rd;
        logic        ld;
        int          n, bad;
        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            ty = ld ? types[$urandom_range(0, 4)] : types[$urandom_range(0, 2)];
            a  = (i % 5 == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
            sd = $urandom; rd = 5'($urandom);
            n  = beats_of(ty);
            do_op(ld, ~ld, ty, a, sd, rd, $urandom_range(0, 2), $urandom_range(0, 2));
            bad = 0;
            if (ld) begin
                if (rq_addr.size() != n || wq_addr.size() != 0) bad++;
                else for (int k = 0; k < n; k++) if (rq_addr[k] !== 32'(a + k)) bad++;
            end else begin
                if (wq_addr.size() != n || rq_addr.size() != 0) bad++;
                else for (int k = 0; k < n; k++) if (wq_addr[k] !== 32'(a + k) || wq_data[k] !== sd[8*k +: 8]) bad++;
            end
            checks++;
            if (bad != 0 || addr_slip != 0 || done_c < 0) begin
                failures++; $display("FAIL rand_beats[%0d]: got bad=%0d slips=%0d done=%0d reads=%0d writes=%0d, want n=%0d clean",
                                     i, bad, addr_slip, done_c, rq_addr.size(), wq_addr.size(), n);
            end
            checks++;
            if (ld ? (d_wdata !== exp_load(ty, a) || d_wreg !== 1'b1 || d_rd !== rd)
                   : (d_wdata !== 32'd0 || d_wreg !== 1'b0 || d_rd !== 5'd0)) begin
                failures++; $display("FAIL rand_result[%0d]: got wdata=%h wreg=%b rd=%0d, want wdata=%h (load=%b type=%b addr=%h)",
                                     i, d_wdata, d_wreg, d_rd, ld ? exp_load(ty, a) : 32'd0, ld, ty, a);
            end
            checks++;
            if (wreg_in_stall != 0 || hold_err != 0 || post_busy !== 1'b0) begin
                failures++; $display("FAIL rand_ctrl[%0d]: got wreg_in_stall=%0d hold_err=%0d busy=%b, want 0 0 0",
                                     i, wreg_in_stall, hold_err, post_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_narrow_loads();
        test_store_wrap();
        test_toggle_grant();
        test_done_hold();
        test_both_high();
        test_io_serial();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory stage of the 5-stage RV32I pipeline. Sits between ex_mem and mem_wb.
- Executes loads and stores over the shared byte-wide RAM port. Multi-byte accesses are split into sequential byte beats.
- Raises a stall request until the access completes.
- Drives mem_rd, mem_wdata and mem_wreg into mem_wb. Non-memory instructions pass straight through.

Parameters:
- ADDR_W, 32, byte address width. Addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rd_i  in  5  destination register from ex_mem
- wdata_i  in  32  ALU result for non-memory ops
- wreg_i  in  1  register write enable from ex_mem
- load_i  in  1  instruction is a load
- store_i  in  1  instruction is a store
- ls_type_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_addr_i  in  32  effective address
- store_data_i  in  32  rs2 value
- stall  in  7  pipeline stall vector; bit 3 = MEM stage
- mem_req_o  out  1  byte request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  byte address
- mem_dout_o  out  8  store byte
- mem_gnt_i  in  1  request accepted this cycle
- mem_din_i  in  8  read byte, valid the cycle after a granted read
- stallreq_o  out  1  MEM stage stall request
- mem_rd  out  5  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_wreg  out  1  to mem_wb

Behaviour:
- Reset (async, rst=1): state IDLE; byte counter 0; result 0; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_dout_o=0; stallreq_o=0; mem_rd=0; mem_wdata=0; mem_wreg=0.
- Reset mid-access aborts the access. Any in-flight read byte is discarded. No partial write-back.
- Beat count N: 1 for B/BU, 2 for H/HU, 4 for W.
- Beat k uses address mem_addr_i+k, wrapping modulo 2^32. Misaligned addresses are legal.
- Byte order is little-endian. Store beat k drives store_data_i[8k+7:8k].
- States:
  - IDLE: if load_i or store_i, go to ACCESS with k=0. Otherwise stay in IDLE and pass rd_i, wdata_i and wreg_i combinationally with stallreq_o=0.
  - ACCESS:
    - mem_req_o=1; address and data for beat k are driven.
    - On mem_gnt_i=1, k increments.
    - Back-to-back grants are allowed, so a read beat's data may return while the next beat is being granted.
    - Read byte for beat j is captured into result[8j+7:8j] on the cycle after its grant.
    - When the last beat is granted: a store goes to DONE; a load goes to WAIT_LAST.
  - WAIT_LAST: mem_req_o=0. Capture the final byte, then go to DONE.
  - DONE:
    - Load: result is extended from bit 7 (B) or bit 15 (H) with sign for B/H and zero for BU/HU. W is unchanged.
    - Load outputs: mem_wdata=result, mem_rd=rd_i, mem_wreg=1.
    - Store outputs: mem_wreg=0, mem_rd=0, mem_wdata=0.
    - Leave DONE for IDLE on the first clock with stall[3]=0. Hold DONE while stall[3]=1 (downstream stall).
- stallreq_o: 1 in ACCESS and WAIT_LAST; 0 in IDLE and DONE.
- While stalled in ACCESS or WAIT_LAST, mem_wreg=0.
- mem_gnt_i while mem_req_o=0 is ignored.
- Latency with a grant every cycle:
  - LB = 3 cycles from entry to DONE.
  - LW = 6 cycles.
  - SW = 5 cycles.
- load_i and store_i both high: treated as a load.

Optional Feature:
MEM_LSU_IO_SERIAL_EN:
- Defined: accesses with mem_addr_o[17:16]==2'b11 are I/O accesses and are serialized.
- After each granted beat, mem_req_o drops for one cycle. For reads, the next request waits until the byte is captured. No back-to-back grants.
- Not defined: all addresses use the pipelined beat sequence.

Test Plan:
- LW at 0x100, bytes 0x78,0x56,0x34,0x12, mem_gnt_i always 1 -> four reads at 0x100..0x103; mem_wdata=0x12345678, mem_wreg=1; stallreq_o high for exactly 5 cycles.
- LB at 0x204, byte 0x80 -> 0xFFFFFF80. Same byte via LBU -> 0x00000080. LHU at 0x205, bytes 0xFF,0x80 -> 0x000080FF.
- SH at 0xFFFFFFFF, data 0xABCD -> writes 0xCD at 0xFFFFFFFF and 0xAB at 0x00000000; mem_wreg=0.
- LW with mem_gnt_i toggling 1,0,1,0,... -> same 0x12345678 result; stallreq_o held throughout; address advances only on grants.
- rst asserted during beat 2 of an SW -> all outputs 0 immediately; IDLE; mem_req_o=0. Next ADD (wdata_i=7, rd_i=5) passes through with no stall.
- With MEM_LSU_IO_SERIAL_EN defined, LW at 0x30000 -> mem_req_o pattern 1,0,1,0,1,0,1 and correct result. Without the macro -> 1,1,1,1.
